// File: rtl/arm_isa_pkg.sv
// ISA constants shared between the control-unit decoder and the instruction encoder.
// Holds the opcode enum, condition and command codes, and instruction field positions.
package arm_isa_pkg;

  typedef enum logic [2:0] {
    INS_ADD, INS_SUB, INS_CMP, INS_MOV, INS_STR, INS_LDR, INS_B, INS_BL
  } op_e;

  localparam logic [3:0] COND_AL = 4'b1110;
  localparam logic [3:0] COND_EQ = 4'b0000;
  localparam logic [3:0] COND_NE = 4'b0001;

  localparam logic [3:0] CMD_ADD = 4'b0100;
  localparam logic [3:0] CMD_SUB = 4'b0010;
  localparam logic [3:0] CMD_CMP = 4'b1010;
  localparam logic [3:0] CMD_MOV = 4'b1101;

  localparam logic [1:0] OP_DP  = 2'b00;
  localparam logic [1:0] OP_MEM = 2'b01;
  localparam logic [1:0] OP_BR  = 2'b10;

  localparam int COND_LSB  = 28;
  localparam int OPF_LSB   = 26;
  localparam int FUNCT_LSB = 20;
  localparam int RN_LSB    = 16;
  localparam int RD_LSB    = 12;
  localparam int SRC2_LSB  = 0;

  function automatic logic cond_legal(input logic [3:0] c);
    return (c == COND_AL) || (c == COND_EQ) || (c == COND_NE);
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with combinational head; pointers carry a wrap bit to tell full from empty.
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp, rp;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign head  = mem[rp[AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (push && !full) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  end

  // Storage needs no reset: empty gates every consumer of head.
  always_ff @(posedge clk) begin
    if (push && !full && !reset) mem[wp[AW-1:0]] <= din;
  end

endmodule

// File: rtl/instr_encoder.sv
// Packs symbolic instruction requests into 32-bit words, queues them, and streams them
// into instruction memory at an auto-incrementing address.
module instr_encoder
  import arm_isa_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [2:0]        req_op,
  input  logic [3:0]        req_cond,
  input  logic              req_s,
  input  logic              req_imm_sel,
  input  logic [3:0]        req_rd,
  input  logic [3:0]        req_rn,
  input  logic [3:0]        req_rm,
  input  logic [23:0]       req_imm,
  input  logic              load_base,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              drain_en,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic [ADDR_W:0]   words_written,
  output logic              err_illegal
);

  function automatic logic [31:0] encode(
    input op_e         op,
    input logic [3:0]  cond,
    input logic        s,
    input logic        imm_sel,
    input logic [3:0]  rd,
    input logic [3:0]  rn,
    input logic [3:0]  rm,
    input logic [23:0] imm
  );
    logic [31:0] w;
    logic [11:0] src2;
    logic [3:0]  cmd;
    src2 = imm_sel ? imm[11:0] : {8'b0, rm};
    case (op)
      INS_SUB: cmd = CMD_SUB;
      INS_CMP: cmd = CMD_CMP;
      INS_MOV: cmd = CMD_MOV;
      default: cmd = CMD_ADD;
    endcase
    w = '0;
    w[COND_LSB +: 4] = cond;
    case (op)
      INS_ADD, INS_SUB, INS_CMP, INS_MOV: begin
        w[OPF_LSB +: 2]    = OP_DP;
        w[FUNCT_LSB +: 6]  = {imm_sel, cmd, (op == INS_CMP) ? 1'b1 : s};
        w[RN_LSB +: 4]     = (op == INS_MOV) ? 4'h0 : rn;
        w[RD_LSB +: 4]     = (op == INS_CMP) ? 4'h0 : rd;
        w[SRC2_LSB +: 12]  = src2;
      end
      INS_STR, INS_LDR: begin
        w[OPF_LSB +: 2]    = OP_MEM;
        w[FUNCT_LSB +: 6]  = {imm_sel, 4'b1100, op == INS_LDR};
        w[RN_LSB +: 4]     = rn;
        w[RD_LSB +: 4]     = rd;
        w[SRC2_LSB +: 12]  = src2;
      end
      default: begin
        w[OPF_LSB +: 2]    = OP_BR;
        w[25:24]           = {1'b1, op == INS_BL};
        w[23:0]            = imm;
      end
    endcase
    return w;
  endfunction

  logic        full, empty, push, accept;
  logic [31:0] enc_word, head;

  assign enc_word  = encode(op_e'(req_op), req_cond, req_s, req_imm_sel,
                            req_rd, req_rn, req_rm, req_imm);
  assign req_ready = !full;
  assign accept    = req_valid && req_ready;
  assign push      = accept && cond_legal(req_cond);

  // load_base steals the cycle so the new address is never written with a stale word.
  assign imem_we    = drain_en && !empty && !load_base;
  assign imem_wdata = empty ? 32'h0 : head;

  sync_fifo #(.WIDTH(32), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (imem_we),
    .din   (enc_word),
    .full  (full),
    .empty (empty),
    .head  (head)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      imem_addr     <= '0;
      words_written <= '0;
      err_illegal   <= 1'b0;
    end else begin
      if (load_base)    imem_addr <= base_addr;
      else if (imem_we) imem_addr <= imem_addr + 1'b1;
      if (imem_we && (words_written != '1)) words_written <= words_written + 1'b1;
      if (accept && !cond_legal(req_cond)) err_illegal <= 1'b1;
    end
  end

endmodule

// File: tb/tb_instr_encoder.sv
// Randomized and directed bench for instr_encoder against a queue-based reference model.
module tb_instr_encoder;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 6;

  logic              clk, reset;
  logic              req_valid, req_ready;
  logic [2:0]        req_op;
  logic [3:0]        req_cond;
  logic              req_s, req_imm_sel;
  logic [3:0]        req_rd, req_rn, req_rm;
  logic [23:0]       req_imm;
  logic              load_base;
  logic [ADDR_W-1:0] base_addr;
  logic              drain_en;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic [ADDR_W:0]   words_written;
  logic              err_illegal;

  instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_cond(req_cond), .req_s(req_s), .req_imm_sel(req_imm_sel),
    .req_rd(req_rd), .req_rn(req_rn), .req_rm(req_rm), .req_imm(req_imm),
    .load_base(load_base), .base_addr(base_addr), .drain_en(drain_en),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .words_written(words_written), .err_illegal(err_illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int pass_cnt = 0;
  int chk_cnt  = 0;

  // reference model state
  logic [31:0] mq[$];
  int          m_addr = 0;
  int          m_cnt  = 0;
  bit          m_err  = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got === exp) pass_cnt++;
    else $display("FAIL %s got=%h exp=%h", tag, got, exp);
  endtask

  // Words built from field values with plain arithmetic.
  function automatic logic [31:0] ref_enc(input int op, input int cond, input int s,
                                          input int isel, input int rd, input int rn,
                                          input int rm, input int imm);
    int cmdv [4] = '{4, 2, 10, 13};
    int funct, opf, src2, rdv, rnv;
    rdv  = rd;
    rnv  = rn;
    src2 = isel ? (imm % 4096) : rm;
    if (op >= 6)
      return 32'(cond) * 32'h1000_0000 + 32'h0A00_0000 + ((op == 7) ? 32'h0100_0000 : 0)
             + 32'(imm % 16777216);
    if (op < 4) begin
      opf   = 0;
      funct = isel * 32 + cmdv[op] * 2 + ((op == 2) ? 1 : s);
      if (op == 2) rdv = 0;
      if (op == 3) rnv = 0;
    end else begin
      opf   = 1;
      funct = isel * 32 + 24 + ((op == 5) ? 1 : 0);
    end
    return 32'(cond) * 32'h1000_0000 + 32'(opf) * 32'h0400_0000 + 32'(funct) * 32'h0010_0000
           + 32'(rnv) * 32'h1_0000 + 32'(rdv) * 32'h1000 + 32'(src2);
  endfunction

  // Called just after a negedge with inputs set; checks outputs, advances one cycle.
  task automatic tick();
    bit rdy, we, leg;
    logic [31:0] hd;
    #1;
    rdy = mq.size() < DEPTH;
    we  = drain_en && (mq.size() > 0) && !load_base;
    hd  = (mq.size() > 0) ? mq[0] : 32'h0;
    if (!reset) begin
      chk("req_ready", 32'(req_ready), 32'(rdy));
      chk("imem_we", 32'(imem_we), 32'(we));
      chk("imem_wdata", imem_wdata, hd);
    end
    chk("imem_addr", 32'(imem_addr), 32'(m_addr));
    chk("words_written", 32'(words_written), 32'(m_cnt));
    chk("err_illegal", 32'(err_illegal), 32'(m_err));
    leg = (req_cond == 4'hE) || (req_cond == 4'h0) || (req_cond == 4'h1);
    @(posedge clk);
    if (reset) begin
      mq.delete();
      m_addr = 0;
      m_cnt  = 0;
      m_err  = 0;
    end else begin
      if (we) begin
        void'(mq.pop_front());
        m_addr = (m_addr + 1) % (1 << ADDR_W);
        if (m_cnt < (1 << (ADDR_W + 1)) - 1) m_cnt++;
      end
      if (load_base) m_addr = int'(base_addr);
      if (req_valid && rdy) begin
        if (leg) mq.push_back(ref_enc(int'(req_op), int'(req_cond), int'(req_s),
                                      int'(req_imm_sel), int'(req_rd), int'(req_rn),
                                      int'(req_rm), int'(req_imm)));
        else m_err = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic req(input int op, input int cond, input int s, input int isel,
                     input int rd, input int rn, input int rm, input int imm);
    req_valid   = 1'b1;
    req_op      = 3'(op);
    req_cond    = 4'(cond);
    req_s       = 1'(s);
    req_imm_sel = 1'(isel);
    req_rd      = 4'(rd);
    req_rn      = 4'(rn);
    req_rm      = 4'(rm);
    req_imm     = 24'(imm);
  endtask

  task automatic set_base(input int a);
    load_base = 1'b1;
    base_addr = ADDR_W'(a);
    tick();
    load_base = 1'b0;
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; load_base = 1'b0; base_addr = '0; drain_en = 1'b0;
    req(0, 14, 0, 0, 0, 0, 0, 0);
    req_valid = 1'b0;
    @(negedge clk);
    tick(); tick();
    reset = 1'b0;
    #1;
    chk("rst_addr", 32'(imem_addr), 32'h0);
    chk("rst_we", 32'(imem_we), 32'h0);
    chk("rst_wdata", imem_wdata, 32'h0);

    // ADD AL rd=1 rn=2 rm=3, latency one cycle to the memory port
    drain_en = 1'b1;
    req(0, 14, 0, 0, 1, 2, 3, 0); tick();
    req_valid = 1'b0; #1;
    chk("add_we", 32'(imem_we), 32'h1);
    chk("add_word", imem_wdata, 32'hE0821003);
    tick();

    // MOV EQ imm / CMP NE reg
    drain_en = 1'b0;
    set_base(0);
    req(3, 0, 0, 1, 0, 9, 0, 5); tick();
    req(2, 1, 0, 0, 3, 4, 5, 0); tick();
    req_valid = 1'b0; drain_en = 1'b1; #1;
    chk("mov_word", imem_wdata, 32'h03A00005);
    tick(); #1;
    chk("cmp_word", imem_wdata, 32'h11540005);
    chk("cmp_addr", 32'(imem_addr), 32'h1);
    tick();

    // LDR / STR / BL
    drain_en = 1'b0;
    req(5, 14, 0, 1, 6, 7, 0, 8); tick();
    req(4, 14, 0, 0, 6, 7, 1, 0); tick();
    req(7, 14, 0, 1, 0, 0, 0, 16); tick();
    req_valid = 1'b0;
    set_base(16);
    drain_en = 1'b1; #1;
    chk("ldr_word", imem_wdata, 32'hE7976008);
    tick(); #1;
    chk("str_word", imem_wdata, 32'hE5876001);
    tick(); #1;
    chk("bl_word", imem_wdata, 32'hEB000010);
    chk("bl_addr", 32'(imem_addr), 32'h12);
    tick();

    // fill to full, hold a 9th request, then drain
    drain_en = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      req(i % 8, 14, i % 2, i % 2, i, i + 1, i + 2, i * 37); tick();
    end
    req(1, 14, 1, 0, 9, 10, 11, 0); #1;
    chk("full_ready", 32'(req_ready), 32'h0);
    tick(); tick();
    drain_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (req_ready) begin tick(); break; end
      tick();
    end
    req_valid = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("drained", 32'(mq.size()), 32'h0);

    // address wrap, then load_base over a non-empty FIFO
    drain_en = 1'b0;
    set_base(63);
    req(0, 14, 1, 1, 2, 3, 4, 255); tick();
    req(6, 14, 0, 0, 0, 0, 0, 24'hABCDEF); tick();
    req_valid = 1'b0; drain_en = 1'b1; #1;
    chk("wrap_addr0", 32'(imem_addr), 32'h3F);
    tick(); #1;
    chk("wrap_addr1", 32'(imem_addr), 32'h00);
    tick();
    drain_en = 1'b0;
    req(1, 1, 1, 0, 5, 6, 7, 0); tick();
    req_valid = 1'b0; drain_en = 1'b1; load_base = 1'b1; base_addr = 6'd5; #1;
    chk("lb_no_we", 32'(imem_we), 32'h0);
    tick();
    load_base = 1'b0; #1;
    chk("lb_addr", 32'(imem_addr), 32'h5);
    tick();

    // illegal condition: handshake completes, nothing queued, sticky error
    req(0, 5, 0, 0, 1, 2, 3, 0); #1;
    chk("ill_ready", 32'(req_ready), 32'h1);
    tick();
    req_valid = 1'b0; #1;
    chk("ill_err", 32'(err_illegal), 32'h1);
    chk("ill_no_we", 32'(imem_we), 32'h0);
    tick(); tick();

    // reset mid-drain
    drain_en = 1'b0;
    for (int i = 0; i < 3; i++) begin req(i, 14, 0, 0, i, i, i, 0); tick(); end
    req_valid = 1'b0; drain_en = 1'b1; tick();
    reset = 1'b1; tick();
    reset = 1'b0; #1;
    chk("mid_rst_we", 32'(imem_we), 32'h0);
    chk("mid_rst_cnt", 32'(words_written), 32'h0);
    chk("mid_rst_err", 32'(err_illegal), 32'h0);
    tick();

    // random traffic, long enough to saturate words_written and wrap the address
    for (int i = 0; i < 1500; i++) begin
      int c;
      c = $urandom_range(0, 19);
      req($urandom_range(0, 7), (c < 8) ? 14 : (c < 13) ? 0 : (c < 18) ? 1 : $urandom_range(0, 15),
          $urandom_range(0, 1), $urandom_range(0, 1), $urandom_range(0, 15),
          $urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 24'hFFFFFF));
      req_valid = ($urandom_range(0, 9) < 7);
      drain_en  = ($urandom_range(0, 9) < 7);
      load_base = ($urandom_range(0, 49) == 0);
      base_addr = ADDR_W'($urandom_range(0, 63));
      tick();
    end
    req_valid = 1'b0; load_base = 1'b0; #1;
    chk("sat_count", 32'(words_written), 32'h7F);

    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
